divider_scheduler: RTL and testbench



---
 rtl/divider_sched_pkg.sv | 14 +
 rtl/divider_scheduler_rr_arbiter.sv | 30 +++
 rtl/divider_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_divider_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_sched_pkg.sv
// Shared state encoding and default widths for divider_scheduler.
package divider_sched_pkg;

  localparam int unsigned SPEED_W_DEF = 20;
  localparam int unsigned DUR_W_DEF   = 16;

  typedef logic [1:0] state_t;

  localparam state_t StIdle    = 2'd0;
  localparam state_t StLoad    = 2'd1;
  localparam state_t StRun     = 2'd2;
  localparam state_t StRelease = 2'd3;

endpackage

// File: rtl/divider_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             valid_o
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((32'(ptr_i) + i) % N_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/divider_scheduler.sv
// Round-robin time-sharing of one programmable clock divider among N_REQ requesters.
// Define DIVSCHED_TIMEOUT_EN to build the watchdog that releases a divider that stops toggling.
module divider_scheduler
  import divider_sched_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned SPEED_W        = SPEED_W_DEF,
  parameter int unsigned DUR_W          = DUR_W_DEF,
  parameter int unsigned IDLE_SPEED     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*SPEED_W-1:0] req_speed,
  input  logic [N_REQ*DUR_W-1:0]   req_periods,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic                     err,
  output logic                     busy,
  output logic [SPEED_W-1:0]       div_speed,
  output logic                     div_rst,
  input  logic                     div_clk
);

  localparam int unsigned PtrW = $clog2(N_REQ);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   sel_q, sel_d;
  logic [PtrW-1:0]    sel_idx_q, sel_idx_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [DUR_W-1:0]   periods_q, periods_d;
  logic [DUR_W-1:0]   cnt_q, cnt_d;
  logic               div_clk_q, div_clk_d;
  logic               done_q, done_d;

  logic [N_REQ-1:0]   arb_gnt;
  logic               arb_valid;
  logic [PtrW-1:0]    arb_idx;
  logic [SPEED_W-1:0] speed_sel;
  logic [DUR_W-1:0]   cnt_inc;
  logic               rise;
  logic               owner_req;
  logic               timeout;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .PTR_W(PtrW)
  ) u_arb (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .gnt_o  (arb_gnt),
    .valid_o(arb_valid)
  );

  always_comb begin
    arb_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) arb_idx = PtrW'(i);
    end
  end

  assign speed_sel = req_speed[arb_idx*SPEED_W +: SPEED_W];
  assign rise      = div_clk & ~div_clk_q;
  assign owner_req = |(req & sel_q);
  assign cnt_inc   = cnt_q + DUR_W'(1);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    sel_idx_d = sel_idx_q;
    ptr_d     = ptr_q;
    speed_d   = speed_q;
    periods_d = periods_q;
    cnt_d     = cnt_q;
    div_clk_d = div_clk_q;
    done_d    = done_q;
    case (state_q)
      StIdle: begin
        if (arb_valid) begin
          sel_d     = arb_gnt;
          sel_idx_d = arb_idx;
          // The divider must never be programmed with speed 0.
          speed_d   = (speed_sel == '0) ? SPEED_W'(1) : speed_sel;
          periods_d = req_periods[arb_idx*DUR_W +: DUR_W];
          state_d   = StLoad;
        end
      end
      StLoad: begin
        cnt_d     = '0;
        div_clk_d = 1'b0;
        if (periods_q == '0) begin
          done_d  = 1'b1;
          state_d = StRelease;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        div_clk_d = div_clk;
        if (!owner_req) begin
          state_d = StRelease;
        end else if (timeout) begin
          state_d = StRelease;
        end else if (rise) begin
          cnt_d = cnt_inc;
          if (cnt_inc == periods_q) begin
            done_d  = 1'b1;
            state_d = StRelease;
          end
        end
      end
      StRelease: begin
        done_d  = 1'b0;
        ptr_d   = (sel_idx_q == PtrW'(N_REQ - 1)) ? '0 : sel_idx_q + PtrW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      sel_idx_q <= '0;
      ptr_q     <= '0;
      speed_q   <= SPEED_W'(IDLE_SPEED);
      periods_q <= '0;
      cnt_q     <= '0;
      div_clk_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      sel_idx_q <= sel_idx_d;
      ptr_q     <= ptr_d;
      speed_q   <= speed_d;
      periods_q <= periods_d;
      cnt_q     <= cnt_d;
      div_clk_q <= div_clk_d;
      done_q    <= done_d;
    end
  end

`ifdef DIVSCHED_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d;

  // Counts RUN cycles since RUN entry or the last divider rise.
  assign timeout = (state_q == StRun) && (wd_q == WdW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d  = wd_q;
    err_d = err_q;
    if (state_q == StLoad) begin
      wd_d = '0;
    end else if (state_q == StRun) begin
      wd_d = rise ? '0 : wd_q + WdW'(1);
    end
    if ((state_q == StRun) && owner_req && timeout) begin
      err_d = 1'b1;
    end else if (state_q == StRelease) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = (state_q == StRelease) & err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    busy      = (state_q == StLoad) || (state_q == StRun);
    grant     = busy ? sel_q : '0;
    div_speed = busy ? speed_q : SPEED_W'(IDLE_SPEED);
    div_rst   = (state_q != StRun);
    done      = ((state_q == StRelease) && done_q) ? sel_q : '0;
  end

endmodule

// File: tb/tb_divider_scheduler.sv
// Self-checking bench for divider_scheduler, driving div_clk from a behavioural divider.
module tb_divider_scheduler;

  localparam int N    = 4;
  localparam int SW   = 20;
  localparam int DW   = 16;
  localparam int BASE = 100;
  localparam int TO   = 50;
`ifdef DIVSCHED_TIMEOUT_EN
  // Keep every divider gap inside the watchdog window so only the forced stall times out.
  localparam int MAX_PER = 40;
`else
  localparam int MAX_PER = BASE;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*SW-1:0] req_speed;
  logic [N*DW-1:0] req_periods;
  logic [N-1:0]    grant, done;
  logic            err, busy;
  logic [SW-1:0]   div_speed;
  logic            div_rst, div_clk;
  logic            force_low;

  int n_cmp = 0;
  int n_bad = 0;
  int ptr_m = 0;
  int lat, rc, w, rises;
  logic prev;

  always #5 clk = ~clk;

  divider_scheduler #(
    .N_REQ(N), .SPEED_W(SW), .DUR_W(DW), .IDLE_SPEED(1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_speed(req_speed), .req_periods(req_periods),
    .grant(grant), .done(done), .err(err), .busy(busy), .div_speed(div_speed),
    .div_rst(div_rst), .div_clk(div_clk)
  );

  // Divider model: output period BASE/speed base cycles, low first half, held low in reset.
  function automatic int div_period(input logic [SW-1:0] s);
    int p;
    p = (s == 0) ? BASE : BASE / int'(s);
    if (p > MAX_PER) p = MAX_PER;
    if (p < 2) p = 2;
    return p;
  endfunction

  int dcnt = 0;
  always @(posedge clk) begin
    if (div_rst) dcnt <= 0;
    else if (dcnt + 1 >= div_period(div_speed)) dcnt <= 0;
    else dcnt <= dcnt + 1;
  end
  assign div_clk = !force_low && (dcnt >= div_period(div_speed) / 2);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int idx, input int spd, input int per, input logic on);
    req_speed[idx*SW +: SW]   = SW'(spd);
    req_periods[idx*DW +: DW] = DW'(per);
    req[idx]                  = on;
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) begin
      if (m[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // Waits for a grant, counts divider rises while the divider runs, checks the release cycle.
  task automatic run_txn(input int idx, input int exp_spd, input int per,
                         output int lat_o, output int run_o);
    int r;
    logic pv;
    lat_o = 0;
    while (grant == 0 && lat_o < 40) begin
      @(negedge clk);
      lat_o++;
    end
    if (grant == 0) begin
      chk("grant_seen", 0, 1);
      run_o = 0;
      return;
    end
    chk("grant", grant, 64'(1) << idx);
    chk("div_speed_load", div_speed, exp_spd);
    chk("busy_load", busy, 1);
    r = 0; pv = 1'b0; run_o = 0;
    do begin
      @(negedge clk);
      run_o++;
      if (grant != 0) begin
        if (run_o == 1 && per > 0) chk("div_rst_run", div_rst, 0);
        if (!div_rst) begin
          if (div_clk && !pv) r++;
          pv = div_clk;
        end
      end
    end while (grant != 0 && run_o < per * 250 + 20);
    if (grant != 0) begin
      chk("release_seen", 0, 1);
      return;
    end
    chk("done", done, 64'(1) << idx);
    chk("rises", r, per);
    chk("err_normal", err, 0);
    chk("idle_speed", div_speed, 1);
    chk("div_rst_rel", div_rst, 1);
    chk("busy_rel", busy, 0);
    ptr_m = (idx + 1) % N;
  endtask

  typedef struct {
    int idx;
    int spd;
    int per;
    int exp_spd;
  } vec_t;
  vec_t tbl[5];

  logic [N-1:0] mask;
  int spd_r[N];
  int per_r[N];

  initial begin
    tbl[0] = '{idx: 1, spd: 10, per: 3, exp_spd: 10};
    tbl[1] = '{idx: 2, spd: 25, per: 0, exp_spd: 25};
    tbl[2] = '{idx: 0, spd: 50, per: 1, exp_spd: 50};
    tbl[3] = '{idx: 3, spd: 0,  per: 2, exp_spd: 1};
    tbl[4] = '{idx: 1, spd: 7,  per: 2, exp_spd: 7};

    rst = 1'b1; req = '0; req_speed = '0; req_periods = '0; force_low = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_speed", div_speed, 1);
    chk("rst_div_rst", div_rst, 1);
    rst = 1'b0;
    @(negedge clk);

    // Directed single-requester vectors.
    for (int k = 0; k < 5; k++) begin
      set_req(tbl[k].idx, tbl[k].spd, tbl[k].per, 1'b1);
      run_txn(tbl[k].idx, tbl[k].exp_spd, tbl[k].per, lat, rc);
      chk("latency", lat, 1);
      if (tbl[k].per == 0) chk("no_run_cycles", rc, 1);
      req[tbl[k].idx] = 1'b0;
      @(negedge clk);
    end

    // Abort: requester 2 drops after its first divider period.
    set_req(2, 10, 5, 1'b1);
    w = 0;
    while (grant == 0 && w < 40) begin @(negedge clk); w++; end
    chk("drop_grant", grant, 4'b0100);
    rises = 0; prev = 1'b0; w = 0;
    while (rises < 1 && w < 200) begin
      @(negedge clk); w++;
      if (!div_rst) begin
        if (div_clk && !prev) rises++;
        prev = div_clk;
      end
    end
    chk("drop_rise_seen", rises, 1);
    req[2] = 1'b0;
    @(negedge clk);
    chk("drop_grant_rel", grant, 0);
    chk("drop_no_done", done, 0);
    chk("drop_div_rst", div_rst, 1);
    ptr_m = 3;
    @(negedge clk);

    // Reset mid-RUN, then a fresh request set must start from requester 0.
    set_req(3, 10, 5, 1'b1);
    w = 0;
    while (grant == 0 && w < 40) begin @(negedge clk); w++; end
    repeat (4) @(negedge clk);
    chk("pre_rst_running", div_rst, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_speed", div_speed, 1);
    chk("mid_rst_div_rst", div_rst, 1);
    set_req(0, 30, 1, 1'b1);
    rst = 1'b0;
    ptr_m = 0;
    run_txn(pick(req, ptr_m), 30, 1, lat, rc);
    chk("post_rst_latency", lat, 1);
    req = '0;
    @(negedge clk);

    // All four held: strict rotation with two idle cycles between grants.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
    for (int i = 0; i < N; i++) set_req(i, 50, 1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      run_txn(k % N, 50, 1, lat, rc);
      chk("rot_latency", lat, (k == 0) ? 1 : 2);
    end
    req = '0;
    @(negedge clk);

    // Randomised rounds against the round-robin model.
    for (int round = 0; round < 6; round++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        spd_r[i] = $urandom_range(0, 60);
        per_r[i] = $urandom_range(0, 3);
        set_req(i, spd_r[i], per_r[i], mask[i]);
      end
      while (mask != 0) begin
        int e;
        e = pick(mask, ptr_m);
        run_txn(e, (spd_r[e] == 0) ? 1 : spd_r[e], per_r[e], lat, rc);
        mask[e] = 1'b0;
        req[e]  = 1'b0;
      end
      @(negedge clk);
    end

`ifdef DIVSCHED_TIMEOUT_EN
    // Stalled divider: the watchdog releases after TO cycles of RUN.
    force_low = 1'b1;
    set_req(0, 10, 3, 1'b1);
    w = 0;
    while (grant == 0 && w < 40) begin @(negedge clk); w++; end
    chk("to_grant", grant, 4'b0001);
    rc = 0;
    do begin @(negedge clk); rc++; end while (grant != 0 && rc < 200);
    chk("to_run_cycles", rc, TO + 1);
    chk("to_err", err, 1);
    chk("to_no_done", done, 0);
    chk("to_grant_rel", grant, 0);
    @(negedge clk);
    chk("to_err_pulse", err, 0);
    force_low = 1'b0;
    req = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
